pb_debouncer_multi: RTL and testbench

Parametrised successor to the single-button debouncer. Debounces N independent push-button or switch inputs.
- Each channel has its own 2-flop synchroniser, input-polarity handling and stability counter.
- Outputs per channel: debounced level, one-cycle press pulse, one-cycle release pulse.
- Sits between board pins and control FSMs (e.g. the multicycle datapath step/run controls), replacing per-button debouncer instances.

---
 rtl/pb_debounce_pkg.sv | 21 ++
 rtl/pb_debounce_chan.sv | 109 ++++++++++
 rtl/pb_debouncer_multi.sv | 47 ++++
 tb/tb_pb_debouncer_multi.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pb_debounce_pkg.sv
// Shared definitions for the multi-channel push-button debouncer.
// Default parameter values and the per-channel output bundle.
// Optional hold-time detection is enabled by defining PB_LONG_PRESS_EN.
package pb_debounce_pkg;

  // A level must stay stable for 2^CNT_W_DEF cycles before it is accepted.
  localparam int CNT_W_DEF  = 16;
  // Width of the hold counter; long_press fires after 2^LONG_W_DEF - 1 held cycles.
  localparam int LONG_W_DEF = 24;
  // 1: a low pin means pressed (typical pull-up button wiring).
  localparam bit ACTIVE_LOW_DEF = 1'b1;

  // Everything one channel presents to the top level.
  typedef struct packed {
    logic state;
    logic press;
    logic rel;
    logic long_press;
  } chan_out_t;

endpackage

// File: rtl/pb_debounce_chan.sv
// One debounce channel: 2-flop synchroniser with polarity fold, stability
// counter, registered debounced level and one-cycle press/release pulses.
// With PB_LONG_PRESS_EN defined, a saturating hold counter adds a one-shot
// long_press pulse; otherwise long_press is constant 0.
module pb_debounce_chan
  import pb_debounce_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int LONG_W     = LONG_W_DEF,
  parameter bit ACTIVE_LOW = ACTIVE_LOW_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      pb,
  output chan_out_t out
);

  if (CNT_W < 1 || LONG_W < 1) begin : g_param_chk
    $error("pb_debounce_chan: CNT_W and LONG_W must be at least 1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s0_q, s0_d;
  logic             s1_q, s1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;     // accepted level, one stage ahead of state
  logic             state_q, state_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             idle;
  logic             accept;
  logic             long_p;

  // Synchronise, compare against the accepted level and count stable cycles.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and no latch is inferred.
    s0_d    = pb ^ ACTIVE_LOW;
    s1_d    = s0_q;
    idle    = (s1_q == lvl_q);
    accept  = !idle && (cnt_q == CNT_MAX);
    // The increment that accepts a new level wraps the counter back to 0.
    cnt_d   = idle ? '0 : cnt_q + 1'b1;
    lvl_d   = lvl_q ^ accept;
    // Output stage: state follows the accepted level, and the edge detector
    // compares against state so the pulse rises on the same edge as state.
    state_d = lvl_q;
    press_d = lvl_q & ~state_q;
    rel_d   = ~lvl_q & state_q;
  end

  // All channel state; reset returns the channel to "not pressed".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      state_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, keeping the synchroniser a true 2-stage pipe.
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

`ifdef PB_LONG_PRESS_EN
  localparam logic [LONG_W-1:0] HOLD_MAX = '1;

  logic [LONG_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;

  // Hold counter runs only while pressed, saturates, and fires once on reaching all-ones.
  always_comb begin
    hold_d = '0;
    long_d = 1'b0;
    // Cleared on the release edge itself, not one cycle later.
    if (state_q && state_d) begin
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
      long_d = (hold_q != HOLD_MAX) && (hold_d == HOLD_MAX);
    end
  end

  // Hold counter and its pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_p = long_q;
`else
  assign long_p = 1'b0;
`endif

  assign out = '{state: state_q, press: press_q, rel: rel_q, long_press: long_p};

endmodule

// File: rtl/pb_debouncer_multi.sv
// N_CH independent push-button debouncers behind one bus interface.
// Each bit of pb gets its own pb_debounce_chan; this level only slices buses.
// Define PB_LONG_PRESS_EN to enable per-channel long_press detection.
// The release output is named release_pulse because "release" is a
// SystemVerilog keyword.
module pb_debouncer_multi
  import pb_debounce_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = CNT_W_DEF,
  parameter bit ACTIVE_LOW = ACTIVE_LOW_DEF,
  parameter int LONG_W     = LONG_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] state,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_press
);

  if (N_CH < 1 || N_CH > 32) begin : g_param_chk
    $error("pb_debouncer_multi: N_CH must be in 1..32");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    chan_out_t ch_out;

    pb_debounce_chan #(
      .CNT_W      (CNT_W),
      .LONG_W     (LONG_W),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .clk (clk),
      .rst (rst),
      .pb  (pb[i]),
      .out (ch_out)
    );

    assign state[i]         = ch_out.state;
    assign press[i]         = ch_out.press;
    assign release_pulse[i] = ch_out.rel;
    assign long_press[i]    = ch_out.long_press;
  end

endmodule

// File: tb/tb_pb_debouncer_multi.sv
// Scoreboard bench for pb_debouncer_multi (N_CH=4, CNT_W=4, LONG_W=5, active low).
// Stimulus pushes each expected pulse event (cycle, masks, state) into a queue;
// a negedge monitor pops and compares whenever any pulse output is high.
module tb_pb_debouncer_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pb;
  logic [3:0] state, press, rel, lng;

  always #5 clk = ~clk;

  pb_debouncer_multi #(
    .N_CH       (4),
    .CNT_W      (4),
    .ACTIVE_LOW (1'b1),
    .LONG_W     (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pb            (pb),
    .state         (state),
    .press         (press),
    .release_pulse (rel),
    .long_press    (lng)
  );

  // Count of rising edges seen so far; read only at negedges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
    logic [3:0] state;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int c, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] l, input logic [3:0] s);
    exp_t e;
    e.cyc   = c;
    e.press = p;
    e.rel   = r;
    e.lng   = l;
    e.state = s;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: any pulse must match the oldest expected event exactly.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("missed_event", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if ((press | rel | lng) != 4'b0) begin
        check("press_release_overlap", press & rel, 0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", {press, rel, lng}, 0);
        end else begin
          e = sb.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("event_press", press, e.press);
          check("event_release", rel, e.rel);
          check("event_long", lng, e.lng);
          check("event_state", state, e.state);
        end
      end
    end
  end

  initial begin
    int c, b, d, f, g;

    // 1. Reset with buttons idle high; nothing may happen for 100 cycles.
    rst = 1'b1;
    pb  = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_state", state, 0);
    check("reset_press", press, 0);
    check("reset_release", rel, 0);
    check("reset_long", lng, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_state", state, 0);

    // 2. Clean press on channel 0: accepted 18 edges after the sampling edge.
    c = cyc;
    pb[0] = 1'b0;
    expect_ev(c + 19, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
`ifdef PB_LONG_PRESS_EN
    expect_ev(c + 50, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
`endif
    wait_cyc(c + 18);
    check("ch0_before_accept", state, 4'b0000);
    wait_cyc(c + 19);
    check("ch0_accept", state, 4'b0001);
    wait_cyc(c + 60);

    // 3. Bounce on channel 1 every 5 cycles; only the final hold is accepted.
    for (int i = 0; i < 40; i++) begin
      pb[1] = ~pb[1];
      repeat (5) @(negedge clk);
    end
    check("ch1_bounce_state", state, 4'b0001);
    b = cyc;
    pb[1] = 1'b0;
    expect_ev(b + 19, 4'b0010, 4'b0000, 4'b0000, 4'b0011);
`ifdef PB_LONG_PRESS_EN
    expect_ev(b + 50, 4'b0000, 4'b0000, 4'b0010, 4'b0011);
`endif
    wait_cyc(b + 18);
    check("ch1_before_accept", state, 4'b0001);
    wait_cyc(b + 19);
    check("ch1_accept", state, 4'b0011);
    wait_cyc(b + 55);

    // 4. Channels 2 and 3 pressed, then released together.
    c = cyc;
    pb[3:2] = 2'b00;
    expect_ev(c + 19, 4'b1100, 4'b0000, 4'b0000, 4'b1111);
`ifdef PB_LONG_PRESS_EN
    expect_ev(c + 50, 4'b0000, 4'b0000, 4'b1100, 4'b1111);
`endif
    wait_cyc(c + 55);
    d = cyc;
    pb[3:2] = 2'b11;
    expect_ev(d + 19, 4'b0000, 4'b1100, 4'b0000, 4'b0011);
    wait_cyc(d + 19);
    check("ch23_released", state, 4'b0011);
    wait_cyc(d + 25);

    // Release channel 0 so it can be re-pressed for the reset test.
    d = cyc;
    pb[0] = 1'b1;
    expect_ev(d + 19, 4'b0000, 4'b0001, 4'b0000, 4'b0010);
    wait_cyc(d + 25);
    check("ch0_released", state, 4'b0010);

    // 5. Reset while channel 0 counter sits at 10 and channel 1 is held.
    f = cyc;
    pb[0] = 1'b0;
    wait_cyc(f + 12);
    rst = 1'b1;
    #1;
    check("async_reset_state", state, 0);
    check("async_reset_press", press, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    g = cyc;
    expect_ev(g + 19, 4'b0011, 4'b0000, 4'b0000, 4'b0011);
`ifdef PB_LONG_PRESS_EN
    expect_ev(g + 50, 4'b0000, 4'b0000, 4'b0011, 4'b0011);
`endif
    wait_cyc(g + 18);
    check("post_reset_before_accept", state, 4'b0000);
    wait_cyc(g + 60);
    check("post_reset_state", state, 4'b0011);
    check("final_long_idle", lng, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
